trax_move_parser: RTL and testbench
===================================

TRAX_MOVE_PARSER -- requirements
Module: trax_move_parser

Interface
REQ-001 The block SHALL have these parameters: none; every width and code below is fixed.
REQ-002 The block SHALL have these ports:
  clock        in   1   single clock; all logic samples on posedge.
  reset        in   1   synchronous, active-high.
  rx_data      in   8   received ASCII byte from the UART.
  rx_valid     in   1   one-cycle strobe; rx_data is valid while it is high.
  color        out  1   0 = White ('W'), 1 = Black ('B').
  color_valid  out  1   level; high once the colour line has been accepted.
  move_out     out  22  [9:0] column, [19:10] row, [21:20] tile type.
  move_valid   out  1   one-cycle pulse; move_out is valid on that cycle.
  parse_error  out  1   one-cycle pulse on a rejected byte.
  busy         out  1   high while a move line is partially received.

Function
REQ-003 The FSM SHALL use states WAIT_COLOR, COLOR_EOL, IDLE, COL, ROW, TYPE_DONE and DISCARD. All transitions SHALL occur only on a rising clock edge with rx_valid=1.
REQ-004 WAIT_COLOR: 'W' or 'B' latches color and goes to COLOR_EOL. Any other byte pulses parse_error and stays in WAIT_COLOR.
REQ-005 COLOR_EOL: '\n' (0x0A) sets color_valid and goes to IDLE. Any other byte pulses parse_error and returns to WAIT_COLOR.
REQ-006 IDLE and COL: a byte '@'..'Z' (0x40..0x5A) is shifted into a column buffer of at most 2 letters, and the state becomes COL. A third letter is an error.
REQ-007 COL and ROW: a byte '0'..'9' is accumulated as row = row*10 + digit, and the state becomes ROW. A fourth digit is an error. A digit in IDLE is an error.
REQ-008 ROW: '+' sets type 00, '\' (0x5C) sets type 01, '/' (0x2F) sets type 10; the state becomes TYPE_DONE.
REQ-009 TYPE_DONE: '\n' loads move_out and pulses move_valid on the next cycle (latency 1), then the state returns to IDLE.
REQ-010 Column value: one letter L gives L-0x40, so '@'=0, 'A'=1, 'Z'=26. Two letters H,L give 26*(H-0x40)+(L-0x40), with H restricted to 'A'..'Z'. Two letters with H='@' are an error.
REQ-011 Row value: 0..999, zero-extended to 10 bits. Leading zeros are accepted.
REQ-012 Any byte not allowed by REQ-006..REQ-009 (including '\n' in COL or ROW) pulses parse_error and moves to DISCARD.
REQ-013 DISCARD: all bytes are ignored until '\n', which returns the FSM to IDLE without a move_valid pulse. The '\n' that caused the error SHALL itself return the FSM directly to IDLE.
REQ-014 '\n' in IDLE SHALL be ignored silently (empty line).
REQ-015 busy SHALL be 1 in COL, ROW, TYPE_DONE and DISCARD, and 0 otherwise.
REQ-016 move_out SHALL hold its last value between pulses. A partially parsed move SHALL never alter move_out.
REQ-017 rx_valid=0 SHALL leave all state unchanged. rx_data SHALL be ignored when rx_valid=0.

Reset
REQ-018 reset=1 at a clock edge SHALL force state=WAIT_COLOR and clear the buffers.
REQ-019 reset SHALL set these outputs to 0: color, color_valid, move_out, move_valid, parse_error, busy.
REQ-020 reset SHALL override a simultaneous rx_valid, and a line in progress when reset asserts SHALL be dropped.

Configuration
REQ-021 When the macro TRAX_PARSER_CR_EN is defined, a carriage return (0x0D) received in COLOR_EOL, TYPE_DONE, IDLE or DISCARD SHALL be ignored without changing state. This makes "\r\n" line endings legal.
REQ-022 When TRAX_PARSER_CR_EN is not defined, 0x0D SHALL be handled as any other illegal byte under REQ-004, REQ-005 and REQ-012.

Verification
REQ-023 Colour line: reset, then bytes 'B','\n' -> color=1 and color_valid=1; no parse_error.
REQ-024 Basic move: after the colour line, bytes 'A','1','2','+','\n' -> one move_valid pulse one cycle after the '\n', with move_out = {2'b00, 10'd12, 10'd1}.
REQ-025 Limits: bytes '@','0','/','\n' give {2'b10, 0, 0}. Bytes 'A','A','9','9','9','\','\n' give {2'b01, 10'd999, 10'd27}.
REQ-026 Error recovery:
  - bytes 'A','B','C' -> parse_error pulses on the 'C'.
  - bytes '1','+','\n' after that -> no move_valid; busy goes low after the '\n'.
  - a following valid move -> parsed correctly.
REQ-027 Reset mid-line: bytes 'C','4', then reset -> state WAIT_COLOR and outputs zero. A subsequent 'W','\n','B','7','/','\n' gives color=0 and move_out={2'b10, 10'd7, 10'd2}.
REQ-028 CR handling: bytes 'A','1','+','\r','\n':
  - with TRAX_PARSER_CR_EN defined -> move_valid pulses.
  - without it -> parse_error pulses and no move_valid.

Source files
------------

// File: rtl/trax_move_parser.sv
// Byte-stream parser for Trax protocol lines: a colour line, then "<col><row><type>\n" moves.
// Define TRAX_PARSER_CR_EN to ignore carriage returns at line boundaries ("\r\n" endings).
module trax_move_parser (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        color,
  output logic        color_valid,
  output logic [21:0] move_out,
  output logic        move_valid,
  output logic        parse_error,
  output logic        busy
);

  typedef enum logic [2:0] {
    WAIT_COLOR,
    COLOR_EOL,
    IDLE,
    COL,
    ROW,
    TYPE_DONE,
    DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic        color_q, color_d;
  logic        color_valid_q, color_valid_d;
  logic [4:0]  col_hi_q, col_hi_d;
  logic [4:0]  col_lo_q, col_lo_d;
  logic [1:0]  col_cnt_q, col_cnt_d;
  logic [9:0]  row_q, row_d;
  logic [1:0]  row_cnt_q, row_cnt_d;
  logic [1:0]  type_q, type_d;
  logic [21:0] move_q, move_d;
  logic        move_valid_q, move_valid_d;
  logic        perr_q, perr_d;
  logic        reject;

  logic        is_letter, is_digit, is_nl, is_cr;
  logic [9:0]  col_val;

  assign is_letter = (rx_data >= 8'h40) && (rx_data <= 8'h5A);
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_nl     = (rx_data == 8'h0A);
`ifdef TRAX_PARSER_CR_EN
  assign is_cr     = (rx_data == 8'h0D);
`else
  assign is_cr     = 1'b0;
`endif

  // Letters '@'..'Z' map to 0..26 through their low five bits.
  assign col_val = ({5'b0, col_hi_q} * 10'd26) + {5'b0, col_lo_q};

  always_comb begin
    state_d       = state_q;
    color_d       = color_q;
    color_valid_d = color_valid_q;
    col_hi_d      = col_hi_q;
    col_lo_d      = col_lo_q;
    col_cnt_d     = col_cnt_q;
    row_d         = row_q;
    row_cnt_d     = row_cnt_q;
    type_d        = type_q;
    move_d        = move_q;
    move_valid_d  = 1'b0;
    perr_d        = 1'b0;
    reject        = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        WAIT_COLOR: begin
          if (rx_data == 8'h57 || rx_data == 8'h42) begin
            color_d = (rx_data == 8'h42);
            state_d = COLOR_EOL;
          end else begin
            perr_d = 1'b1;
          end
        end
        COLOR_EOL: begin
          if (is_nl) begin
            color_valid_d = 1'b1;
            state_d       = IDLE;
          end else if (!is_cr) begin
            perr_d  = 1'b1;
            state_d = WAIT_COLOR;
          end
        end
        IDLE: begin
          if (is_letter) begin
            col_hi_d  = '0;
            col_lo_d  = rx_data[4:0];
            col_cnt_d = 2'd1;
            row_d     = '0;
            row_cnt_d = '0;
            state_d   = COL;
          end else if (!(is_nl || is_cr)) begin
            reject = 1'b1;
          end
        end
        COL: begin
          // A two-letter column may not start with '@'.
          if (is_letter) begin
            if (col_cnt_q == 2'd1 && col_lo_q != 5'd0) begin
              col_hi_d  = col_lo_q;
              col_lo_d  = rx_data[4:0];
              col_cnt_d = 2'd2;
            end else begin
              reject = 1'b1;
            end
          end else if (is_digit) begin
            row_d     = (row_q * 10'd10) + {6'b0, rx_data[3:0]};
            row_cnt_d = 2'd1;
            state_d   = ROW;
          end else begin
            reject = 1'b1;
          end
        end
        ROW: begin
          if (is_digit) begin
            if (row_cnt_q < 2'd3) begin
              row_d     = (row_q * 10'd10) + {6'b0, rx_data[3:0]};
              row_cnt_d = row_cnt_q + 2'd1;
            end else begin
              reject = 1'b1;
            end
          end else if (rx_data == 8'h2B) begin
            type_d  = 2'b00;
            state_d = TYPE_DONE;
          end else if (rx_data == 8'h5C) begin
            type_d  = 2'b01;
            state_d = TYPE_DONE;
          end else if (rx_data == 8'h2F) begin
            type_d  = 2'b10;
            state_d = TYPE_DONE;
          end else begin
            reject = 1'b1;
          end
        end
        TYPE_DONE: begin
          if (is_nl) begin
            move_d       = {type_q, row_q, col_val};
            move_valid_d = 1'b1;
            state_d      = IDLE;
          end else if (!is_cr) begin
            reject = 1'b1;
          end
        end
        DISCARD: begin
          if (is_nl) begin
            state_d = IDLE;
          end
        end
        default: state_d = WAIT_COLOR;
      endcase

      // A rejected newline already ends the line, so skip DISCARD for it.
      if (reject) begin
        perr_d  = 1'b1;
        state_d = is_nl ? IDLE : DISCARD;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= WAIT_COLOR;
      color_q       <= 1'b0;
      color_valid_q <= 1'b0;
      col_hi_q      <= '0;
      col_lo_q      <= '0;
      col_cnt_q     <= '0;
      row_q         <= '0;
      row_cnt_q     <= '0;
      type_q        <= '0;
      move_q        <= '0;
      move_valid_q  <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
      col_hi_q      <= col_hi_d;
      col_lo_q      <= col_lo_d;
      col_cnt_q     <= col_cnt_d;
      row_q         <= row_d;
      row_cnt_q     <= row_cnt_d;
      type_q        <= type_d;
      move_q        <= move_d;
      move_valid_q  <= move_valid_d;
      perr_q        <= perr_d;
    end
  end

  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign move_out    = move_q;
  assign move_valid  = move_valid_q;
  assign parse_error = perr_q;
  assign busy        = (state_q == COL) || (state_q == ROW) ||
                       (state_q == TYPE_DONE) || (state_q == DISCARD);

endmodule

// File: tb/tb_trax_move_parser.sv
// Self-checking bench for trax_move_parser: table-driven move lines plus hand-written corner sequences.
module tb_trax_move_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        color, color_valid, move_valid, parse_error, busy;
  logic [21:0] move_out;

  trax_move_parser dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .color       (color),
    .color_valid (color_valid),
    .move_out    (move_out),
    .move_valid  (move_valid),
    .parse_error (parse_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    string       line;
    bit          has_move;
    logic [21:0] exp;
    int unsigned n_err;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned err_seen = 0;
  logic [21:0] sb[$];
  logic [21:0] last_move = '0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [21:0] mv(logic [1:0] t, int unsigned r, int unsigned c);
    return {t, 10'(r), 10'(c)};
  endfunction

  // Output monitor: scoreboard for move pulses, counter for error pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if (parse_error) err_seen++;
      if (move_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_move: got move_out=%0h, expected no move_valid", move_out);
        end else begin
          logic [21:0] e;
          e = sb.pop_front();
          check("move_out", {10'b0, move_out}, {10'b0, e});
          last_move = e;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    if (gap) begin
      rx_data = 8'($urandom);
      @(negedge clock);
    end
  endtask

  task automatic send_str(input string s, input bit gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb.delete();
    last_move = '0;
  endtask

  task automatic run_vec(input vec_t v, input bit gap);
    int unsigned base;
    base = err_seen;
    if (v.has_move) sb.push_back(v.exp);
    send_str(v.line, gap);
    repeat (2) @(negedge clock);
    check({v.name, ":err_count"}, err_seen - base, v.n_err);
    check({v.name, ":pending_moves"}, sb.size(), 0);
    check({v.name, ":move_out_hold"}, {10'b0, move_out}, {10'b0, last_move});
    check({v.name, ":busy_after_eol"}, {31'b0, busy}, 0);
  endtask

  vec_t vecs[18];
  vec_t v;

  initial begin
    vecs[0]  = '{"basic",      "A12+\n",      1'b1, mv(2'b00, 12, 1),   0};
    vecs[1]  = '{"min",        "@0/\n",       1'b1, mv(2'b10, 0, 0),    0};
    vecs[2]  = '{"max",        "AA999\\\n",   1'b1, mv(2'b01, 999, 27), 0};
    vecs[3]  = '{"z_single",   "Z0\\\n",      1'b1, mv(2'b01, 0, 26),   0};
    vecs[4]  = '{"zz",         "ZZ5+\n",      1'b1, mv(2'b00, 5, 702),  0};
    vecs[5]  = '{"lead_zero",  "B007/\n",     1'b1, mv(2'b10, 7, 2),    0};
    vecs[6]  = '{"low_at",     "A@3/\n",      1'b1, mv(2'b10, 3, 26),   0};
    vecs[7]  = '{"empty",      "\n",          1'b0, '0, 0};
    vecs[8]  = '{"three_let",  "ABC\n",       1'b0, '0, 1};
    vecs[9]  = '{"at_high",    "@A1+\n",      1'b0, '0, 1};
    vecs[10] = '{"four_dig",   "A1234+\n",    1'b0, '0, 1};
    vecs[11] = '{"nl_in_col",  "A\n",         1'b0, '0, 1};
    vecs[12] = '{"nl_in_row",  "A1\n",        1'b0, '0, 1};
    vecs[13] = '{"junk_td",    "A1+X\n",      1'b0, '0, 1};
    vecs[14] = '{"lower",      "a1+\n",       1'b0, '0, 1};
    vecs[15] = '{"dbl_type",   "A1++\n",      1'b0, '0, 1};
    vecs[16] = '{"type_in_col","A+\n",        1'b0, '0, 1};
    vecs[17] = '{"digit_idle", "5/\n",        1'b0, '0, 1};

    // Reset state
    do_reset();
    check("rst:color", {31'b0, color}, 0);
    check("rst:color_valid", {31'b0, color_valid}, 0);
    check("rst:move_out", {10'b0, move_out}, 0);
    check("rst:move_valid", {31'b0, move_valid}, 0);
    check("rst:parse_error", {31'b0, parse_error}, 0);
    check("rst:busy", {31'b0, busy}, 0);

    // Colour line 'B'
    send_byte(8'h42, 1'b1);
    check("col:valid_early", {31'b0, color_valid}, 0);
    send_byte(8'h0A, 1'b0);
    check("col:color", {31'b0, color}, 1);
    check("col:color_valid", {31'b0, color_valid}, 1);
    check("col:errs", err_seen, 0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i[0]);
    // Something inside a move with busy checks mid-line
    send_byte(8'h41, 1'b0);
    check("busy_col", {31'b0, busy}, 1);

    // Error recovery: error must pulse on the third letter
    send_byte(8'h0A, 1'b0);            // finishes the 'A' line above as an error
    repeat (2) @(negedge clock);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    check("abc:no_err_on_B", {31'b0, parse_error}, 0);
    send_byte(8'h43, 1'b0);
    check("abc:err_on_C", {31'b0, parse_error}, 1);
    check("abc:busy_discard", {31'b0, busy}, 1);
    send_str("1+", 1'b0);
    check("abc:busy_still", {31'b0, busy}, 1);
    send_byte(8'h0A, 1'b0);
    check("abc:busy_low", {31'b0, busy}, 0);
    repeat (2) @(negedge clock);
    v = '{"recover", "D5\\\n", 1'b1, mv(2'b01, 5, 4), 0};
    run_vec(v, 1'b0);

    // Carriage return inside a move line
`ifdef TRAX_PARSER_CR_EN
    v = '{"cr", "A1+\r\n", 1'b1, mv(2'b00, 1, 1), 0};
`else
    v = '{"cr", "A1+\r\n", 1'b0, '0, 1};
`endif
    run_vec(v, 1'b1);

    // Reset mid-line, with a simultaneous valid byte
    send_str("C4", 1'b0);
    check("midrst:busy_before", {31'b0, busy}, 1);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h42;
    @(negedge clock);
    rx_valid = 1'b0;
    check("midrst:color", {31'b0, color}, 0);
    check("midrst:color_valid", {31'b0, color_valid}, 0);
    check("midrst:move_out", {10'b0, move_out}, 0);
    check("midrst:busy", {31'b0, busy}, 0);
    check("midrst:move_valid", {31'b0, move_valid}, 0);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    last_move = '0;
    send_str("W\n", 1'b0);
    check("midrst:color_w", {31'b0, color}, 0);
    check("midrst:color_valid_w", {31'b0, color_valid}, 1);
    v = '{"midrst_move", "B7/\n", 1'b1, mv(2'b10, 7, 2), 0};
    run_vec(v, 1'b0);

    // Colour line errors
    do_reset();
    send_byte(8'h58, 1'b0);
    check("cerr:bad_letter", {31'b0, parse_error}, 1);
    send_byte(8'h57, 1'b0);
    check("cerr:no_err_W", {31'b0, parse_error}, 0);
    send_byte(8'h58, 1'b0);
    check("cerr:bad_eol", {31'b0, parse_error}, 1);
    send_byte(8'h0A, 1'b0);
    check("cerr:nl_in_wait", {31'b0, parse_error}, 1);
    check("cerr:valid_low", {31'b0, color_valid}, 0);
    send_str("W\n", 1'b1);
    check("cerr:color", {31'b0, color}, 0);
    check("cerr:color_valid", {31'b0, color_valid}, 1);
    v = '{"after_cerr", "A1+\n", 1'b1, mv(2'b00, 1, 1), 0};
    run_vec(v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
